gray_to_binary_tracker: RTL and testbench

Receive side of the Gray-coded count path: takes a Gray-coded value from another timing source, resynchronises it to the local clock, decodes it to binary, and tracks its motion. Each step is reported with a one-cycle valid pulse and a direction flag. Illegal multi-bit jumps are flagged in a sticky error bit. A saturating step counter is also maintained. Sits downstream of the binary-to-Gray encoder, which feeds position/pointer sinks.

---
 rtl/gray_to_binary_tracker.sv | 235 +++++++++++++++++++++++
 tb/tb_gray_to_binary_tracker.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_to_binary_tracker.sv
// ---------------------------------------------------------------------------
// gray_to_binary_tracker
//
// Receive side of a Gray-coded count path. A Gray value produced in another
// clock domain is resynchronised, decoded to binary, and its motion is
// tracked. Each accepted step produces a one-cycle valid pulse together with
// the new binary value and a direction flag. Multi-bit jumps between
// consecutive synchronised samples are recorded in a sticky error bit. A
// saturating 16-bit counter counts valid pulses.
//
// Parameters
//   WIDTH        width of the Gray input and binary output (2..16)
//   SYNC_STAGES  synchroniser depth on g_in (2..4)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   g_in       in   [WIDTH] Gray-coded value, asynchronous to clk
//   en         in   tracking enable; 0 holds the outputs
//   err_clr    in   synchronous clear of the sticky error
//   b_out      out  [WIDTH] decoded binary value, registered
//   valid      out  one-cycle pulse when b_out takes a new value
//   dir        out  direction of the last legal step (1 = up, 0 = down)
//   err        out  sticky multi-bit-jump flag
//   step_cnt   out  [16] saturating count of valid pulses
//   state_dbg  out  [2] current FSM state (0 idle, 1 init, 2 track)
//
// Handshake: valid is a pure producer-side strobe with no ready/backpressure.
// A sink must accept b_out/dir/err/step_cnt in the single cycle valid is
// high; the block never stalls or repeats a pulse.
// ---------------------------------------------------------------------------
module gray_to_binary_tracker #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] g_in,
  input  logic             en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] b_out,
  output logic             valid,
  output logic             dir,
  output logic             err,
  output logic [15:0]      step_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Synchroniser. Runs regardless of en so the sample is always fresh when
  // tracking is re-enabled.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] g_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= g_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign g_s = sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Settle counter. After reset the chain still holds the reset zeros; the
  // last stage reflects a real g_in sample only once SYNC_STAGES edges have
  // passed. INIT waits for this so the first baseline is not the reset value
  // (which would otherwise make the first tracked step look like a jump).
  // -------------------------------------------------------------------------
  localparam logic [2:0] SETTLE_MAX = 3'(SYNC_STAGES);

  logic [2:0] settle_q;
  logic       sync_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= '0;
    end else if (settle_q != SETTLE_MAX) begin
      settle_q <= settle_q + 3'd1;
    end
  end

  assign sync_ok = (settle_q == SETTLE_MAX);

  // -------------------------------------------------------------------------
  // Gray decode: each binary bit is the XOR of all Gray bits at or above it.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] b_dec;

  always_comb begin
    b_dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      b_dec[i] = ^(g_s >> i);
    end
  end

  // -------------------------------------------------------------------------
  // Change classification against the last accepted sample. A nonzero value
  // with a single set bit is a legal Gray step; more set bits is a jump.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] g_prev;
  logic [WIDTH-1:0] g_diff;
  logic [WIDTH-1:0] g_diff_m1;
  logic             hd_zero;
  logic             hd_one;
  logic             hd_many;

  assign g_diff    = g_s ^ g_prev;
  assign g_diff_m1 = g_diff - WIDTH'(1);
  assign hd_zero   = (g_diff == '0);
  assign hd_one    = !hd_zero && ((g_diff & g_diff_m1) == '0);
  assign hd_many   = !hd_zero && !hd_one;

  // Direction: a step is "up" only when the new value is exactly one above
  // the old one, modulo 2^WIDTH, so max -> 0 counts as up.
  logic [WIDTH-1:0] b_step;
  logic             step_up;

  assign b_step  = b_dec - b_out;
  assign step_up = (b_step == WIDTH'(1));

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   capture;   // take g_s as the new baseline and emit a pulse
  logic   upd_dir;   // legal single-bit step: refresh dir
  logic   set_err;   // illegal jump: set sticky error

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    upd_dir = 1'b0;
    set_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (sync_ok) begin
          // Rebaseline: no comparison against the stale g_prev.
          capture = 1'b1;
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (!en) begin
          // Re-enable goes through INIT, so motion while disabled is never
          // reported as an error.
          state_d = ST_IDLE;
        end else if (hd_one) begin
          capture = 1'b1;
          upd_dir = 1'b1;
        end else if (hd_many) begin
          capture = 1'b1;
          set_err = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign state_dbg = state_q;

  // -------------------------------------------------------------------------
  // Output and compare registers. All of them change on the capture edge so
  // the sink sees a coherent set alongside valid.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_prev <= '0;
      b_out  <= '0;
      valid  <= 1'b0;
      dir    <= 1'b0;
    end else begin
      valid <= capture;
      if (capture) begin
        g_prev <= g_s;
        b_out  <= b_dec;
      end
      if (upd_dir) begin
        dir <= step_up;
      end
    end
  end

  // Sticky error; a new jump wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (set_err) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  // Saturating pulse counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (capture && (step_cnt != 16'hFFFF)) begin
      step_cnt <= step_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// ---------------------------------------------------------------------------
// Testbench for gray_to_binary_tracker (WIDTH=4, SYNC_STAGES=2).
// A negedge monitor pops {err, dir, b_out} from exp_q on every valid pulse.
// Directed steps come from a vector table; reset, enable gating, err_clr
// and saturation are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_gray_to_binary_tracker;

  localparam int WIDTH = 4;
  localparam int W     = WIDTH + 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] g_in;
  logic             en;
  logic             err_clr;
  logic [WIDTH-1:0] b_out;
  logic             valid;
  logic             dir;
  logic             err;
  logic [15:0]      step_cnt;
  logic [1:0]       state_dbg;

  gray_to_binary_tracker #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .g_in      (g_in),
    .en        (en),
    .err_clr   (err_clr),
    .b_out     (b_out),
    .valid     (valid),
    .dir       (dir),
    .err       (err),
    .step_cnt  (step_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_exp(input logic e, input logic d, input logic [WIDTH-1:0] b);
    return {e, d, b};
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("pulse_b_out", 32'(b_out), 32'(mon_exp[WIDTH-1:0]));
        check("pulse_dir",   32'(dir),   32'(mon_exp[WIDTH]));
        check("pulse_err",   32'(err),   32'(mon_exp[WIDTH+1]));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic             clr;
    logic [WIDTH-1:0] b;
    logic             dir;
    logic             err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [3:0] g, input logic clr, input logic [3:0] b,
                         input logic d, input logic e);
    vec_t v;
    v.g = g; v.clr = clr; v.b = b; v.dir = d; v.err = e;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a negedge. Capture happens on the third posedge; err_clr is
  // held high across exactly that edge when clr_at_capture is set.
  task automatic drive(input logic [WIDTH-1:0] g, input logic clr_at_capture);
    g_in = g;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    err_clr = clr_at_capture;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge. Resets with g_in already at the given value and en=1.
  task automatic reset_at(input logic [WIDTH-1:0] g);
    rst_n = 1'b0;
    g_in  = g;
    en    = 1'b1;
    wait_neg(2);
    rst_n = 1'b1;
  endtask

  logic [15:0] bin;

  // ---------------- main sequence ----------------
  initial begin
    rst_n   = 1'b0;
    g_in    = '0;
    en      = 1'b0;
    err_clr = 1'b0;

    // Reset values.
    #12;
    check("rst_b_out", 32'(b_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_dir", 32'(dir), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_step_cnt", 32'(step_cnt), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // First INIT after reset: Gray 0111 -> binary 5 after three edges.
    @(negedge clk);
    exp_q.push_back(pack_exp(1'b0, 1'b0, 4'b0101));
    g_in  = 4'b0111;
    en    = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("init_lat_e1_valid", 32'(valid), 32'd0);
    @(negedge clk);
    check("init_lat_e2_valid", 32'(valid), 32'd0);
    @(negedge clk);
    check("init_lat_e3_valid", 32'(valid), 32'd1);
    check("init_b_out", 32'(b_out), 32'h5);
    @(negedge clk);
    check("init_pulse_single", 32'(valid), 32'd0);
    check("init_step_cnt", 32'(step_cnt), 32'd1);
    check("init_err", 32'(err), 32'd0);
    check("init_drained", 32'(exp_q.size()), 32'd0);

    // Rebaseline at 0 for the table.
    exp_q.push_back(pack_exp(1'b0, 1'b0, 4'd0));
    reset_at(4'b0000);
    wait_neg(4);
    check("base0_drained", 32'(exp_q.size()), 32'd0);
    check("base0_step_cnt", 32'(step_cnt), 32'd1);

    // Table: full count up 1..15,0 (wrap is an up step).
    add_vec(4'b0001, 0, 4'd1,  1, 0);
    add_vec(4'b0011, 0, 4'd2,  1, 0);
    add_vec(4'b0010, 0, 4'd3,  1, 0);
    add_vec(4'b0110, 0, 4'd4,  1, 0);
    add_vec(4'b0111, 0, 4'd5,  1, 0);
    add_vec(4'b0101, 0, 4'd6,  1, 0);
    add_vec(4'b0100, 0, 4'd7,  1, 0);
    add_vec(4'b1100, 0, 4'd8,  1, 0);
    add_vec(4'b1101, 0, 4'd9,  1, 0);
    add_vec(4'b1111, 0, 4'd10, 1, 0);
    add_vec(4'b1110, 0, 4'd11, 1, 0);
    add_vec(4'b1010, 0, 4'd12, 1, 0);
    add_vec(4'b1011, 0, 4'd13, 1, 0);
    add_vec(4'b1001, 0, 4'd14, 1, 0);
    add_vec(4'b1000, 0, 4'd15, 1, 0);
    add_vec(4'b0000, 0, 4'd0,  1, 0);
    // Up to 3, then down 2,1,0,15.
    add_vec(4'b0001, 0, 4'd1,  1, 0);
    add_vec(4'b0011, 0, 4'd2,  1, 0);
    add_vec(4'b0010, 0, 4'd3,  1, 0);
    add_vec(4'b0011, 0, 4'd2,  0, 0);
    add_vec(4'b0001, 0, 4'd1,  0, 0);
    add_vec(4'b0000, 0, 4'd0,  0, 0);
    add_vec(4'b1000, 0, 4'd15, 0, 0);
    // Wrap back up 15 -> 0.
    add_vec(4'b0000, 0, 4'd0,  1, 0);
    // Illegal jump 0 -> 2: err set, dir held.
    add_vec(4'b0011, 0, 4'd2,  1, 1);
    // Illegal jump 2 -> 7 with err_clr on the capture edge: set wins.
    add_vec(4'b0100, 1, 4'd7,  1, 1);
    // Legal step down 7 -> 6, err stays sticky.
    add_vec(4'b0101, 0, 4'd6,  0, 1);

    foreach (vecs[i]) begin
      exp_q.push_back(pack_exp(vecs[i].err, vecs[i].dir, vecs[i].b));
      drive(vecs[i].g, vecs[i].clr);
    end
    check("table_drained", 32'(exp_q.size()), 32'd0);
    check("table_step_cnt", 32'(step_cnt), 32'd28);
    check("table_err_sticky", 32'(err), 32'd1);

    // err_clr alone.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr_alone", 32'(err), 32'd0);

    // Disable, move g_in by two bits, re-enable: INIT, no error.
    en = 1'b0;
    wait_neg(2);
    g_in = 4'b1111;
    wait_neg(6);
    check("disabled_hold_b_out", 32'(b_out), 32'h6);
    check("disabled_state", 32'(state_dbg), 32'd0);
    exp_q.push_back(pack_exp(1'b0, 1'b0, 4'b1010));
    en = 1'b1;
    wait_neg(4);
    check("reenable_drained", 32'(exp_q.size()), 32'd0);
    check("reenable_err", 32'(err), 32'd0);
    exp_q.push_back(pack_exp(1'b0, 1'b1, 4'd11));
    drive(4'b1110, 1'b0);
    check("reenable_step_drained", 32'(exp_q.size()), 32'd0);
    check("reenable_step_cnt", 32'(step_cnt), 32'd30);

    // Saturation: INIT (1) + 65534 back-to-back steps = 65535.
    exp_q.push_back(pack_exp(1'b0, 1'b0, 4'd0));
    reset_at(4'b0000);
    wait_neg(4);
    bin = 16'd0;
    for (int n = 0; n < 65534; n++) begin
      bin = bin + 16'd1;
      g_in = bin[3:0] ^ (bin[3:0] >> 1);
      exp_q.push_back(pack_exp(1'b0, 1'b1, bin[3:0]));
      @(negedge clk);
    end
    wait_neg(3);
    check("sat_reach_ffff", 32'(step_cnt), 32'hFFFF);
    check("sat_drained", 32'(exp_q.size()), 32'd0);
    bin = bin + 16'd1;
    g_in = bin[3:0] ^ (bin[3:0] >> 1);
    exp_q.push_back(pack_exp(1'b0, 1'b1, bin[3:0]));
    wait_neg(4);
    check("sat_hold_ffff", 32'(step_cnt), 32'hFFFF);
    check("sat_extra_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-count.
    for (int n = 0; n < 5; n++) begin
      bin = bin + 16'd1;
      g_in = bin[3:0] ^ (bin[3:0] >> 1);
      exp_q.push_back(pack_exp(1'b0, 1'b1, bin[3:0]));
      @(negedge clk);
    end
    #3;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    exp_q.delete();
    check("async_rst_b_out", 32'(b_out), 32'd0);
    check("async_rst_valid", 32'(valid), 32'd0);
    check("async_rst_dir", 32'(dir), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    check("async_rst_step_cnt", 32'(step_cnt), 32'd0);
    check("async_rst_state", 32'(state_dbg), 32'd0);
    wait_neg(2);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      bin = bin + 16'd1;
      g_in = bin[3:0] ^ (bin[3:0] >> 1);
      @(negedge clk);
    end
    check("post_rst_no_pulse_cnt", 32'(step_cnt), 32'd0);
    check("post_rst_b_out", 32'(b_out), 32'd0);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
